// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
//
// Assembles one ALU operation from a byte-serial pad interface. Operand A
// arrives first as NB = WIDTH/8 bytes, least significant byte first. Operand B
// follows in the same order, and a single op byte comes last. Only bits [1:0]
// of the op byte are used, as the operation selector. The complete operation is
// then offered downstream with a valid/ready handshake. The upstream side is
// stalled while the operation waits.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   clear      synchronous abort of any partial or pending transaction
//   in_data    byte-serial input bus
//   in_valid   in_data holds a byte
//   in_ready   loader accepts a byte this cycle (decoded from state only)
//   a, b       assembled operands
//   sel        operation selector
//   out_valid  a/b/sel form a complete, stable operation
//   out_ready  downstream consumes the operation
//   state      debug view of the FSM: 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 ISSUE
// -----------------------------------------------------------------------------
module alu_operand_loader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       state
);

  localparam int NB = WIDTH / 8;
  // The counter needs at least one bit, even when an operand is a single byte.
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("alu_operand_loader: WIDTH must be a multiple of 8 and at least 8");
  end

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    ISSUE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       sel_q, sel_d;

  logic accept;
  logic transfer;
  logic last_byte;

  // Replace byte lane idx of word with data. The other lanes are left untouched.
  function automatic logic [WIDTH-1:0] merge_byte(input logic [WIDTH-1:0] word,
                                                  input logic [CW-1:0]    idx,
                                                  input logic [7:0]       data);
    logic [WIDTH-1:0] res;
    res = word;
    for (int i = 0; i < NB; i++) begin
      if (idx == CW'(i)) res[8*i +: 8] = data;
    end
    return res;
  endfunction

  // The handshake outputs depend on the state alone. They do not look at
  // in_valid or out_ready, so there is no combinational path through the loader.
  assign in_ready  = (state_q != ISSUE);
  assign out_valid = (state_q == ISSUE);
  assign accept    = in_valid && in_ready && !clear;
  assign transfer  = out_valid && out_ready && !clear;
  assign last_byte = (cnt_q == CW'(NB - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first (hold the current
    // value). A path that leaves one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;

    if (clear) begin
      // The abort has priority over any byte or handshake on the same edge.
      // The data registers keep their contents.
      state_d = LOAD_A;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        LOAD_A: if (accept) begin
          a_d = merge_byte(a_q, cnt_q, in_data);
          if (last_byte) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        LOAD_B: if (accept) begin
          b_d = merge_byte(b_q, cnt_q, in_data);
          if (last_byte) begin
            cnt_d   = '0;
            state_d = LOAD_OP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        LOAD_OP: if (accept) begin
          sel_d   = in_data[1:0];
          state_d = ISSUE;
        end
        ISSUE: if (transfer) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  // NOTE: the operand registers are reset along with the control state, because
  // a, b and sel must read as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. All
      // registers then update together from the values computed before the edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign sel   = sel_q;
  assign state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_loader
//
// Bench for alu_operand_loader with WIDTH = 32. A table of 9-byte streams is
// applied together with the expected operands. The expected result is pushed to
// a scoreboard queue when the op byte is sent. It is popped and compared when
// the DUT offers the operation. Hand-written sequences cover the stall, clear
// and asynchronous reset cases.
// -----------------------------------------------------------------------------
module tb_alu_operand_loader;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             clear;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       state;

  alu_operand_loader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One stream: byte 0 sits in stream[7:0] and is sent first. When gap is set,
  // an idle cycle precedes each byte and out_ready is held high while loading.
  typedef struct packed {
    logic [71:0] stream;
    logic        gap;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t        vecs [5];
  logic [65:0] sb_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected debug state after n bytes of an operation have been accepted.
  function automatic logic [1:0] exp_state(input int n);
    if (n < 4)       return 2'd0;
    else if (n < 8)  return 2'd1;
    else if (n == 8) return 2'd2;
    else             return 2'd3;
  endfunction

  task automatic send_byte(input logic [7:0] d, input int n_after, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
      check("gap_state", 64'(state), 64'(exp_state(n_after - 1)));
    end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    check("byte_state", 64'(state), 64'(exp_state(n_after)));
  endtask

  task automatic send_stream(input logic [71:0] s, input bit gap,
                             input logic [31:0] ea, input logic [31:0] eb,
                             input logic [1:0] es);
    logic [71:0] sv;
    sv = s;
    for (int k = 0; k < 9; k++) send_byte(sv[8*k +: 8], k + 1, gap);
    sb_q.push_back({ea, eb, es});
    check("issue_out_valid", 64'(out_valid), 64'd1);
    check("issue_in_ready", 64'(in_ready), 64'd0);
  endtask

  // Wait (bounded) for an offered operation, compare it with the scoreboard,
  // then transfer it.
  task automatic drain();
    logic [65:0] e;
    int          budget;
    budget = 0;
    while (!out_valid && budget < 20) begin
      tick();
      budget++;
    end
    check("issue_wait", 64'(out_valid), 64'd1);
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_underflow: got an operation, expected none queued");
    end else begin
      e = sb_q.pop_front();
      check("a", 64'(a), 64'(e[65:34]));
      check("b", 64'(b), 64'(e[33:2]));
      check("sel", 64'(sel), 64'(e[1:0]));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_xfer_out_valid", 64'(out_valid), 64'd0);
    check("post_xfer_state", 64'(state), 64'd0);
  endtask

  initial begin
    vecs[0] = '{stream: 72'h02_89ABCDEF_12345678, gap: 1'b0,
                exp_a: 32'h12345678, exp_b: 32'h89ABCDEF, exp_sel: 2'd2};
    vecs[1] = '{stream: 72'h02_89ABCDEF_12345678, gap: 1'b1,
                exp_a: 32'h12345678, exp_b: 32'h89ABCDEF, exp_sel: 2'd2};
    vecs[2] = '{stream: 72'h01_00000002_00000001, gap: 1'b0,
                exp_a: 32'h00000001, exp_b: 32'h00000002, exp_sel: 2'd1};
    vecs[3] = '{stream: 72'hFF_88776655_44332211, gap: 1'b1,
                exp_a: 32'h44332211, exp_b: 32'h88776655, exp_sel: 2'd3};
    vecs[4] = '{stream: 72'h7C_07060504_03020100, gap: 1'b0,
                exp_a: 32'h03020100, exp_b: 32'h07060504, exp_sel: 2'd0};

    // Reset state. A byte is offered across an edge while rst is high, and it
    // must not be taken.
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    out_ready = 1'b0;
    #3;
    check("rst_state", 64'(state), 64'd0);
    check("rst_a", 64'(a), 64'd0);
    check("rst_b", 64'(b), 64'd0);
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("rst_edge_a", 64'(a), 64'd0);
    check("rst_edge_state", 64'(state), 64'd0);
    #4;
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    // Table-driven streams. Gapped vectors also keep out_ready high while
    // loading, which must have no effect.
    for (int v = 0; v < 5; v++) begin
      out_ready = vecs[v].gap;
      send_stream(vecs[v].stream, vecs[v].gap, vecs[v].exp_a, vecs[v].exp_b, vecs[v].exp_sel);
      drain();
    end

    // Stall in ISSUE while upstream keeps offering 0xFF.
    send_stream(vecs[0].stream, 1'b0, vecs[0].exp_a, vecs[0].exp_b, vecs[0].exp_sel);
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_a", 64'(a), 64'h12345678);
      check("stall_b", 64'(b), 64'h89ABCDEF);
      check("stall_sel", 64'(sel), 64'd2);
    end
    in_valid = 1'b0;
    drain();

    // Clear after three A bytes. The clear leaves the partial operand intact.
    send_byte(8'hAA, 1, 1'b0);
    send_byte(8'hBB, 2, 1'b0);
    send_byte(8'hCC, 3, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_state", 64'(state), 64'd0);
    check("clear_a_kept", 64'(a[23:0]), 64'hCCBBAA);
    send_stream(vecs[2].stream, 1'b0, 32'h1, 32'h2, 2'd1);
    drain();

    // Clear together with a valid byte in LOAD_B. The byte must not be taken.
    send_byte(8'h10, 1, 1'b0);
    send_byte(8'h20, 2, 1'b0);
    send_byte(8'h30, 3, 1'b0);
    send_byte(8'h40, 4, 1'b0);
    send_byte(8'h77, 5, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_b_state", 64'(state), 64'd0);
    check("clr_b_b", 64'(b), 64'h00000077);
    check("clr_b_a", 64'(a), 64'h40302010);
    send_stream(vecs[2].stream, 1'b0, 32'h1, 32'h2, 2'd1);
    drain();

    // Asynchronous reset pulse between edges during LOAD_B.
    for (int k = 0; k < 6; k++) send_byte(8'(8'h31 + k), k + 1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_a", 64'(a), 64'd0);
    check("arst_b", 64'(b), 64'd0);
    check("arst_sel", 64'(sel), 64'd0);
    check("arst_state", 64'(state), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    #1;
    rst = 1'b0;
    tick();
    send_stream(vecs[0].stream, 1'b0, vecs[0].exp_a, vecs[0].exp_b, vecs[0].exp_sel);
    drain();

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d queued, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
